// File: rtl/double_to_sig16b.sv
// Converts one IEEE-754 binary64 sample to a 16-bit signed PCM sample, scaled by
// 2^SCALE_EXP, using a five-step FSM with round-half-to-even and saturation.
module double_to_sig16b #(
  parameter int SCALE_EXP = 0
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] double,
  output logic [15:0] sig16b,
  output logic        ready,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ROUND, S_WRITE, S_DONE
  } state_t;

  localparam logic signed [12:0] SCALE_E = 13'(SCALE_EXP);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;

  logic [63:0]        r_operand;
  logic               r_sign_p0;
  logic signed [12:0] r_exp_p0;
  logic [51:0]        r_mant_p0;
  logic               r_zero_p0;
  logic               r_inf_p0;
  logic               r_nan_p0;
  logic [15:0]        r_int_p1;
  logic               r_guard_p1;
  logic               r_sticky_p1;
  logic               r_big_p1;
  logic [16:0]        r_mag_p2;
  logic [15:0]        r_sig16b;
  logic               r_overflow;

  logic signed [12:0] w_exp;
  logic [52:0]        w_sig;
  logic [52:0]        w_mask;
  logic [5:0]         w_e6;
  logic [15:0]        w_int;
  logic               w_guard;
  logic               w_sticky;
  logic [16:0]        w_result;

  // Half-to-even: bump only on a tie with an odd integer part, or above the tie.
  function automatic logic [16:0] f_round(input logic [15:0] mag, input logic guard,
                                          input logic sticky);
    logic inc;
    inc = guard & (sticky | mag[0]);
    return {1'b0, mag} + {16'd0, inc};
  endfunction

  // Returns {overflow, sample}.
  function automatic logic [16:0] f_saturate(input logic sign, input logic nan,
                                             input logic inf, input logic zero,
                                             input logic big, input logic [16:0] mag);
    if (nan)
      return {1'b1, 16'h0000};
    if (inf || big)
      return sign ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF};
    if (zero)
      return {1'b0, 16'h0000};
    if (sign) begin
      if (mag > 17'd32768)
        return {1'b1, 16'h8000};
      return {1'b0, 16'(17'd0 - mag)};
    end
    if (mag >= 17'd32768)
      return {1'b1, 16'h7FFF};
    return {1'b0, mag[15:0]};
  endfunction

  assign w_accept = enable && (r_state == S_IDLE || r_state == S_DONE);
  assign busy     = (r_state == S_UNPACK) || (r_state == S_ALIGN) ||
                    (r_state == S_ROUND)  || (r_state == S_WRITE);
  assign ready    = (r_state == S_DONE);
  assign sig16b   = r_sig16b;
  assign overflow = r_overflow;

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_UNPACK;
      S_UNPACK: w_next = S_ALIGN;
      S_ALIGN:  w_next = S_ROUND;
      S_ROUND:  w_next = S_WRITE;
      S_WRITE:  w_next = S_DONE;
      S_DONE:   if (w_accept) w_next = S_UNPACK;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_exp = $signed({2'b00, r_operand[62:52]}) - 13'sd1023 + SCALE_E;
  assign w_e6  = r_exp_p0[5:0];

  always_comb begin
    w_sig    = {1'b1, r_mant_p0};
    w_mask   = '0;
    w_int    = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (r_exp_p0 >= 13'sd0 && r_exp_p0 <= 13'sd15) begin
      w_int    = 16'(w_sig >> (6'd52 - w_e6));
      w_guard  = w_sig[6'd51 - w_e6];
      w_mask   = (53'd1 << (6'd51 - w_e6)) - 53'd1;
      w_sticky = |(w_sig & w_mask);
    end else if (r_exp_p0 == -13'sd1) begin
      w_guard  = 1'b1;
      w_sticky = |r_mant_p0;
    end else if (r_exp_p0 < -13'sd1) begin
      w_sticky = 1'b1;
    end
  end

  assign w_result = f_saturate(r_sign_p0, r_nan_p0, r_inf_p0, r_zero_p0, r_big_p1, r_mag_p2);

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      r_operand   <= '0;
      r_sign_p0   <= 1'b0;
      r_exp_p0    <= '0;
      r_mant_p0   <= '0;
      r_zero_p0   <= 1'b0;
      r_inf_p0    <= 1'b0;
      r_nan_p0    <= 1'b0;
      r_int_p1    <= '0;
      r_guard_p1  <= 1'b0;
      r_sticky_p1 <= 1'b0;
      r_big_p1    <= 1'b0;
      r_mag_p2    <= '0;
      r_sig16b    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) r_operand <= double;
        end
        // p0: field split and operand classification
        S_UNPACK: begin
          r_sign_p0 <= r_operand[63];
          r_exp_p0  <= w_exp;
          r_mant_p0 <= r_operand[51:0];
          r_zero_p0 <= (r_operand[62:52] == 11'd0);
          r_inf_p0  <= (r_operand[62:52] == 11'h7FF) && (r_operand[51:0] == 52'd0);
          r_nan_p0  <= (r_operand[62:52] == 11'h7FF) && (r_operand[51:0] != 52'd0);
        end
        // p1: integer part plus guard/sticky
        S_ALIGN: begin
          r_int_p1    <= w_int;
          r_guard_p1  <= w_guard;
          r_sticky_p1 <= w_sticky;
          r_big_p1    <= (r_exp_p0 >= 13'sd16);
        end
        // p2: rounded 17-bit magnitude
        S_ROUND: begin
          r_mag_p2 <= f_round(r_int_p1, r_guard_p1, r_sticky_p1);
        end
        S_WRITE: begin
          r_overflow <= w_result[16];
          r_sig16b   <= w_result[15:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_double_to_sig16b.sv
// Scoreboard bench for double_to_sig16b: one instance at SCALE_EXP=0, one at SCALE_EXP=15.
module tb_double_to_sig16b;

  typedef struct packed {
    logic [15:0] v;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en15;
  logic [63:0] d0, d15;
  logic [15:0] sig0, sig15;
  logic        rdy0, rdy15, busy0, busy15, ovf0, ovf15;

  exp_t        q0[$];
  exp_t        q15[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] last0 = 16'h0000;
  logic [15:0] last15 = 16'h0000;
  logic        rq0 = 1'b0;
  logic        rq15 = 1'b0;

  always #5 clk = ~clk;

  double_to_sig16b #(.SCALE_EXP(0)) dut0 (
    .clk_operation(clk), .rst(rst), .enable(en0), .double(d0),
    .sig16b(sig0), .ready(rdy0), .busy(busy0), .overflow(ovf0)
  );

  double_to_sig16b #(.SCALE_EXP(15)) dut15 (
    .clk_operation(clk), .rst(rst), .enable(en15), .double(d15),
    .sig16b(sig15), .ready(rdy15), .busy(busy15), .overflow(ovf15)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, req);
  endtask

  // Scoreboard: pop one expected result on each rising edge of ready.
  always @(negedge clk) begin
    exp_t e;
    if (rdy0 && !rq0) begin
      if (q0.size() == 0) chk_eq("spurious_ready0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk_eq("sig16b_s0", 32'(sig0), 32'(e.v));
        chk_eq("overflow_s0", 32'(ovf0), 32'(e.o));
      end
    end
    if (rdy15 && !rq15) begin
      if (q15.size() == 0) chk_eq("spurious_ready15", 32'd1, 32'd0);
      else begin
        e = q15.pop_front();
        chk_eq("sig16b_s15", 32'(sig15), 32'(e.v));
        chk_eq("overflow_s15", 32'(ovf15), 32'(e.o));
      end
    end
    if (rdy0 && busy0)   chk_eq("ready_and_busy0", 32'd1, 32'd0);
    if (rdy15 && busy15) chk_eq("ready_and_busy15", 32'd1, 32'd0);
    rq0  = rdy0;
    rq15 = rdy15;
  end

  task automatic convert(input bit s15, input logic [63:0] d, input logic [15:0] ev,
                         input logic eo, input bit repulse);
    int          lat;
    int          nb;
    exp_t        e;
    logic [15:0] prev;
    e.v = ev;
    e.o = eo;
    @(negedge clk);
    if (s15) begin q15.push_back(e); d15 = d; en15 = 1'b1; prev = last15; end
    else     begin q0.push_back(e);  d0 = d;  en0 = 1'b1;  prev = last0;  end
    @(posedge clk);
    @(negedge clk);
    if (s15) en15 = 1'b0; else en0 = 1'b0;
    chk_eq("hold_sig16b", 32'(s15 ? sig15 : sig0), 32'(prev));
    chk_eq("ready_cleared", 32'(s15 ? rdy15 : rdy0), 32'd0);
    lat = 0;
    nb  = 0;
    while (!(s15 ? rdy15 : rdy0) && lat < 20) begin
      if (s15 ? busy15 : busy0) nb++;
      if (repulse && lat == 1) begin d0 = 64'hC004000000000000; en0 = 1'b1; end
      if (repulse && lat == 2) en0 = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk_eq("latency", 32'(lat), 32'd4);
    chk_eq("busy_cycles", 32'(nb), 32'd4);
    if (s15) last15 = ev; else last0 = ev;
  endtask

  initial begin
    int cnt;
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b0; en0 = 1'b0; en15 = 1'b0; d0 = '0; d15 = '0;
    #12;
    chk_eq("reset_sig16b", 32'(sig0), 32'd0);
    chk_eq("reset_ready", 32'(rdy0), 32'd0);
    chk_eq("reset_busy", 32'(busy0), 32'd0);
    chk_eq("reset_overflow", 32'(ovf0), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    convert(0, 64'h3FF0000000000000, 16'h0001, 1'b0, 0);
    convert(0, 64'hC004000000000000, 16'hFFFE, 1'b0, 0);
    convert(0, 64'h400C000000000000, 16'h0004, 1'b0, 1);
    convert(0, 64'h3FE0000000000000, 16'h0000, 1'b0, 0);
    convert(0, 64'hBFD0000000000000, 16'h0000, 1'b0, 0);
    convert(0, 64'h8000000000000000, 16'h0000, 1'b0, 0);
    convert(0, 64'h40DFFFE000000000, 16'h7FFF, 1'b1, 0);
    convert(0, 64'hC0E0000000000000, 16'h8000, 1'b0, 0);
    convert(0, 64'h40F0000000000000, 16'h7FFF, 1'b1, 0);
    convert(0, 64'hC0F86A0000000000, 16'h8000, 1'b1, 0);
    convert(0, 64'h7FF8000000000000, 16'h0000, 1'b1, 0);
    convert(0, 64'hFFF0000000000000, 16'h8000, 1'b1, 0);
    convert(0, 64'h7FF0000000000000, 16'h7FFF, 1'b1, 0);
    convert(0, 64'h0000000000000001, 16'h0000, 1'b0, 0);
    convert(0, 64'h40E3880000000000, 16'h7FFF, 1'b1, 0);
    convert(1, 64'h3FE0000000000000, 16'h4000, 1'b0, 0);
    convert(1, 64'hBFF0000000000000, 16'h8000, 1'b0, 0);
    convert(1, 64'h3FF0000000000000, 16'h7FFF, 1'b1, 0);

    // Asynchronous reset while the converter sits in ROUND.
    @(negedge clk);
    d0 = 64'h3FF0000000000000;
    en0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_eq("abort_sig16b", 32'(sig0), 32'd0);
    chk_eq("abort_overflow", 32'(ovf0), 32'd0);
    chk_eq("abort_busy", 32'(busy0), 32'd0);
    chk_eq("abort_ready", 32'(rdy0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last0 = 16'h0000;
    last15 = 16'h0000;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy0) cnt++;
    end
    chk_eq("no_ready_after_abort", 32'(cnt), 32'd0);

    // Level enable: one conversion every five edges.
    @(negedge clk);
    for (int i = 0; i < 3; i++) q0.push_back('{v: 16'h0001, o: 1'b0});
    d0 = 64'h3FF0000000000000;
    en0 = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy0) cnt++;
    end
    en0 = 1'b0;
    chk_eq("held_enable_ready_count", 32'(cnt), 32'd3);

    repeat (4) @(negedge clk);
    chk_eq("queue0_drained", 32'(q0.size()), 32'd0);
    chk_eq("queue15_drained", 32'(q15.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
